// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: classifies retiring instructions into records and queues them in a FIFO.
// Optional macro TRACE_CYCLE_STAMP_EN adds a per-record 16-bit cycle stamp (out_stamp).
module retire_trace_buffer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] pc,
  input  logic [15:0] inst,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        hlt,
  input  logic [3:0]  wr_reg,
  input  logic [15:0] wr_data,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_kind,
  output logic [15:0] out_pc,
  output logic [15:0] out_inst,
  output logic [3:0]  out_reg,
  output logic [15:0] out_data0,
  output logic [15:0] out_data1,
`ifdef TRACE_CYCLE_STAMP_EN
  output logic [15:0] out_stamp,
`endif
  output logic [31:0] inst_count,
  output logic [31:0] cycle_count,
  output logic [15:0] drop_count,
  output logic        overflow,
  output logic        done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [2:0] K_REG   = 3'd0;
  localparam logic [2:0] K_LOAD  = 3'd1;
  localparam logic [2:0] K_STORE = 3'd2;
  localparam logic [2:0] K_NOP   = 3'd3;
  localparam logic [2:0] K_HALT  = 3'd4;

  typedef struct packed {
    logic [2:0]  kind;
    logic [15:0] pc;
    logic [15:0] inst;
    logic [3:0]  rd;
    logic [15:0] d0;
    logic [15:0] d1;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [15:0] stamp;
`endif
  } rec_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  rec_t        mem_q [DEPTH];
  rec_t        rec_d;
  rec_t        head;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] cyc_q, cyc_d;
  logic [15:0] drop_q, drop_d;
  logic        ovf_q, ovf_d;

  logic cap;
  logic pop;
  logic push;
  logic drop;
  logic full;

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          cap     = 1'b1;
          state_d = hlt ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (!en) begin
          state_d = S_IDLE;
        end else begin
          cap = 1'b1;
          if (hlt) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) state_d = S_DONE;
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Priority: load, reg write, halt, store, then nop/branch.
  always_comb begin
    rec_d      = '0;
    rec_d.pc   = pc;
    rec_d.inst = inst;
`ifdef TRACE_CYCLE_STAMP_EN
    rec_d.stamp = cyc_q[15:0];
`endif
    if (reg_write && mem_read) begin
      rec_d.kind = K_LOAD;
      rec_d.rd   = wr_reg;
      rec_d.d0   = wr_data;
      rec_d.d1   = mem_addr;
    end else if (reg_write) begin
      rec_d.kind = K_REG;
      rec_d.rd   = wr_reg;
      rec_d.d0   = wr_data;
    end else if (hlt) begin
      rec_d.kind = K_HALT;
    end else if (mem_write) begin
      rec_d.kind = K_STORE;
      rec_d.d0   = mem_addr;
      rec_d.d1   = mem_data;
    end else begin
      rec_d.kind = K_NOP;
    end
  end

  assign full = (cnt_q == FULL_CNT);
  assign pop  = (cnt_q != '0) && out_ready;
  assign push = cap && (!full || pop);
  assign drop = cap && full && !pop;

  always_comb begin
    rd_d   = pop  ? rd_q + 1'b1 : rd_q;
    wr_d   = push ? wr_q + 1'b1 : wr_q;
    cnt_d  = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    if (pop && !push) cnt_d = cnt_q - 1'b1;
    inst_d = (cap && inst_q != '1) ? inst_q + 1'b1 : inst_q;
    cyc_d  = (cap && cyc_q != '1) ? cyc_q + 1'b1 : cyc_q;
    drop_d = (drop && drop_q != '1) ? drop_q + 1'b1 : drop_q;
    ovf_d  = ovf_q | drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      inst_q  <= '0;
      cyc_q   <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      inst_q  <= inst_d;
      cyc_q   <= cyc_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= rec_d;
  end

  assign head      = mem_q[rd_q];
  assign out_valid = (cnt_q != '0);
  assign out_kind  = out_valid ? head.kind : '0;
  assign out_pc    = out_valid ? head.pc   : '0;
  assign out_inst  = out_valid ? head.inst : '0;
  assign out_reg   = out_valid ? head.rd   : '0;
  assign out_data0 = out_valid ? head.d0   : '0;
  assign out_data1 = out_valid ? head.d1   : '0;
`ifdef TRACE_CYCLE_STAMP_EN
  assign out_stamp = out_valid ? head.stamp : '0;
`endif

  assign inst_count  = inst_q;
  assign cycle_count = cyc_q;
  assign drop_count  = drop_q;
  assign overflow    = ovf_q;
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed self-checking bench for retire_trace_buffer.
// Expected values are hand-computed from the record/FIFO behaviour.
module tb_retire_trace_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] pc, inst;
  logic        reg_write, mem_read, mem_write, hlt;
  logic [3:0]  wr_reg;
  logic [15:0] wr_data, mem_addr, mem_data;
  logic        out_valid, out_ready;
  logic [2:0]  out_kind;
  logic [15:0] out_pc, out_inst;
  logic [3:0]  out_reg;
  logic [15:0] out_data0, out_data1;
  logic [31:0] inst_count, cycle_count;
  logic [15:0] drop_count;
  logic        overflow, done;
`ifdef TRACE_CYCLE_STAMP_EN
  logic [15:0] out_stamp;
`endif

  int checks = 0;
  int errors = 0;

  retire_trace_buffer #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .en(en),
    .pc(pc), .inst(inst),
    .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .hlt(hlt),
    .wr_reg(wr_reg), .wr_data(wr_data),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_kind(out_kind), .out_pc(out_pc), .out_inst(out_inst),
    .out_reg(out_reg), .out_data0(out_data0), .out_data1(out_data1),
`ifdef TRACE_CYCLE_STAMP_EN
    .out_stamp(out_stamp),
`endif
    .inst_count(inst_count), .cycle_count(cycle_count),
    .drop_count(drop_count), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ret(input logic [15:0] p, input logic rw,
                     input logic mr, input logic mw, input logic h,
                     input logic [3:0] rd, input logic [15:0] wd,
                     input logic [15:0] ma, input logic [15:0] md);
    pc = p; inst = p ^ 16'hA5A5;
    reg_write = rw; mem_read = mr; mem_write = mw; hlt = h;
    wr_reg = rd; wr_data = wd; mem_addr = ma; mem_data = md;
  endtask

  initial begin
    logic [15:0] exp_d [8];
    logic [15:0] exp_p [4];
    logic [2:0]  exp_k [4];

    rst = 1'b1; en = 1'b0; out_ready = 1'b0;
    ret(16'h0, 0, 0, 0, 0, 4'd0, 16'h0, 16'h0, 16'h0);
    step();
    step();
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_inst", inst_count, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_data0", {16'b0, out_data0}, 32'd0);
    rst = 1'b0;
    step();
    chk("idle_no_cap", inst_count, 32'd0);

    en = 1'b1; out_ready = 1'b1;
    ret(16'h0000, 1, 0, 0, 0, 4'd3, 16'h0005, 16'h0, 16'h0);
    step();
    chk("reg_valid", {31'b0, out_valid}, 32'd1);
    chk("reg_kind", {29'b0, out_kind}, 32'd0);
    chk("reg_rd", {28'b0, out_reg}, 32'd3);
    chk("reg_d0", {16'b0, out_data0}, 32'h0005);
    chk("reg_d1", {16'b0, out_data1}, 32'h0);
    chk("reg_pc", {16'b0, out_pc}, 32'h0000);
    chk("reg_inst", {16'b0, out_inst}, 32'hA5A5);
    chk("reg_icnt", inst_count, 32'd1);
    chk("reg_ccnt", cycle_count, 32'd1);

    ret(16'h0002, 0, 0, 1, 0, 4'd7, 16'h0, 16'h0010, 16'hBEEF);
    step();
    chk("st_kind", {29'b0, out_kind}, 32'd2);
    chk("st_d0", {16'b0, out_data0}, 32'h0010);
    chk("st_d1", {16'b0, out_data1}, 32'hBEEF);
    chk("st_rd", {28'b0, out_reg}, 32'd0);
    chk("st_icnt", inst_count, 32'd2);

    ret(16'h0004, 1, 1, 0, 0, 4'd5, 16'h00AA, 16'h0020, 16'h0);
    step();
    chk("ld_kind", {29'b0, out_kind}, 32'd1);
    chk("ld_rd", {28'b0, out_reg}, 32'd5);
    chk("ld_d0", {16'b0, out_data0}, 32'h00AA);
    chk("ld_d1", {16'b0, out_data1}, 32'h0020);

    ret(16'h0006, 0, 0, 0, 0, 4'd9, 16'h1111, 16'h2222, 16'h3333);
    step();
    chk("nop_kind", {29'b0, out_kind}, 32'd3);
    chk("nop_d0", {16'b0, out_data0}, 32'h0);
    chk("nop_icnt", inst_count, 32'd4);

    en = 1'b0;
    step();
    chk("pause_valid", {31'b0, out_valid}, 32'd0);
    step();
    chk("pause_icnt", inst_count, 32'd4);

    out_ready = 1'b0; en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ret(16'h0100 + 16'(2 * i), 1, 0, 0, 0, 4'(i), 16'h0100 + 16'(i),
          16'h0, 16'h0);
      step();
    end
    chk("ovf_drop", {16'b0, drop_count}, 32'd2);
    chk("ovf_flag", {31'b0, overflow}, 32'd1);
    chk("ovf_icnt", inst_count, 32'd14);
    chk("ovf_ccnt", cycle_count, 32'd14);
    chk("ovf_head", {16'b0, out_data0}, 32'h0100);
    step();
    chk("ovf_hold", {16'b0, out_data0}, 32'h0100);
    chk("ovf_drop2", {16'b0, drop_count}, 32'd3);

    out_ready = 1'b1;
    ret(16'h0114, 1, 0, 0, 0, 4'd10, 16'h010A, 16'h0, 16'h0);
    step();
    chk("pp_drop", {16'b0, drop_count}, 32'd3);
    chk("pp_icnt", inst_count, 32'd16);

    en = 1'b0;
    exp_d = '{16'h0101, 16'h0102, 16'h0103, 16'h0104,
              16'h0105, 16'h0106, 16'h0107, 16'h010A};
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain_v%0d", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("drain_d%0d", k), {16'b0, out_data0}, {16'b0, exp_d[k]});
      step();
    end
    chk("drain_empty", {31'b0, out_valid}, 32'd0);
    chk("drain_ovf", {31'b0, overflow}, 32'd1);

    out_ready = 1'b0; en = 1'b1;
    exp_p = '{16'h001E, 16'h0020, 16'h0022, 16'h0024};
    exp_k = '{3'd0, 3'd0, 3'd0, 3'd4};
    for (int k = 0; k < 3; k++) begin
      ret(exp_p[k], 1, 0, 0, 0, 4'd1, exp_p[k], 16'h0, 16'h0);
      step();
    end
    ret(16'h0024, 0, 0, 0, 1, 4'd2, 16'h0, 16'h0, 16'h0);
    step();
    chk("hlt_icnt", inst_count, 32'd20);
    ret(16'h0026, 1, 0, 0, 0, 4'd4, 16'h9999, 16'h0, 16'h0);
    step();
    step();
    chk("hlt_nocap", inst_count, 32'd20);
    chk("hlt_notdone", {31'b0, done}, 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("hlt_v%0d", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("hlt_pc%0d", k), {16'b0, out_pc}, {16'b0, exp_p[k]});
      chk($sformatf("hlt_k%0d", k), {29'b0, out_kind}, {29'b0, exp_k[k]});
      step();
    end
    chk("hlt_empty", {31'b0, out_valid}, 32'd0);
    chk("hlt_done0", {31'b0, done}, 32'd0);
    step();
    chk("hlt_done1", {31'b0, done}, 32'd1);
    step();
    chk("hlt_hold", {31'b0, done}, 32'd1);
    chk("hlt_icnt2", inst_count, 32'd20);

    rst = 1'b1; en = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
    en = 1'b1;
    ret(16'h0040, 1, 0, 0, 0, 4'd1, 16'h0040, 16'h0, 16'h0);
    step();
    ret(16'h0042, 1, 0, 0, 0, 4'd1, 16'h0042, 16'h0, 16'h0);
    step();
    ret(16'h0044, 0, 0, 0, 1, 4'd0, 16'h0, 16'h0, 16'h0);
    step();
    chk("mid_valid", {31'b0, out_valid}, 32'd1);
    chk("mid_icnt", inst_count, 32'd3);
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_icnt", inst_count, 32'd0);
    chk("arst_ccnt", cycle_count, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_kind", {29'b0, out_kind}, 32'd0);
    chk("arst_pc", {16'b0, out_pc}, 32'd0);
    rst = 1'b0;
    ret(16'h0050, 1, 0, 0, 0, 4'd6, 16'h0077, 16'h0, 16'h0);
    step();
    chk("post_icnt", inst_count, 32'd1);
    chk("post_d0", {16'b0, out_data0}, 32'h0077);
    chk("post_done", {31'b0, done}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/retire_trace_buffer.md
RETIRE_TRACE_BUFFER -- requirements
Module: retire_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO record entries (power of two, 2..64).
REQ-002 SHALL have ports clk, in, 1, system clock (all state on rising edge).
REQ-003 SHALL have ports rst, in, 1, asynchronous active-high reset.
REQ-004 SHALL have ports en, in, 1, capture enable.
REQ-005 SHALL have ports pc and inst, in, 16 each, PC and instruction of the instruction retiring this cycle.
REQ-006 SHALL have ports reg_write, mem_read, mem_write and hlt, in, 1 each, retire controls.
REQ-007 SHALL have port wr_reg, in, 4, destination register.
REQ-008 SHALL have port wr_data, in, 16, register write data.
REQ-009 SHALL have ports mem_addr and mem_data, in, 16 each, memory address and store data.
REQ-010 SHALL have output out_valid, out, 1, and input out_ready, in, 1, the record stream handshake.
REQ-011 SHALL have port out_kind, out, 3, record kind: 0 REG, 1 LOAD, 2 STORE, 3 NOP/BRANCH, 4 HALT.
REQ-012 SHALL have ports out_pc and out_inst, out, 16 each, record PC and instruction.
REQ-013 SHALL have ports out_reg, out, 4, out_data0, out, 16, and out_data1, out, 16, the record payload.
REQ-014 SHALL have ports inst_count and cycle_count, out, 32 each, statistics.
REQ-015 SHALL have ports drop_count, out, 16; overflow, out, 1; and done, out, 1.

Function
REQ-016 SHALL classify each retire in priority order:
- reg_write&mem_read -> LOAD (out_data0=wr_data, out_data1=mem_addr).
- reg_write -> REG (out_data0=wr_data, out_data1=0).
- hlt -> HALT.
- mem_write -> STORE (out_data0=mem_addr, out_data1=mem_data).
- else -> NOP/BRANCH.
- out_reg=wr_reg for REG/LOAD, 0 otherwise; unused data fields 0.
REQ-017 SHALL implement FSM IDLE, RUN, DRAIN, DONE:
- IDLE->RUN when en=1.
- RUN->IDLE when en=0; counters and FIFO hold.
- RUN->DRAIN on the cycle hlt=1 is captured.
- DRAIN->DONE when FIFO is empty.
- DONE is held until reset.
REQ-018 SHALL capture exactly one record per clock while in RUN (including the en=1 transition cycle out of IDLE) and none in IDLE, DRAIN or DONE.
REQ-019 SHALL increment cycle_count every clock in RUN.
REQ-020 SHALL increment inst_count per captured record, dropped or not.
REQ-021 SHALL saturate cycle_count and inst_count at 0xFFFFFFFF and drop_count at 0xFFFF.
REQ-022 SHALL push a captured record into the FIFO with one-cycle latency: record captured at edge N gives out_valid=1 after edge N; there is no combinational bypass.
REQ-023 SHALL pop the head entry on a clock edge where out_valid&out_ready; out_* SHALL hold stable while out_valid&!out_ready.
REQ-024 SHALL, when the FIFO is full and no pop occurs that cycle, drop the record, increment drop_count, and set sticky overflow.
REQ-025 SHALL treat full with simultaneous pop and push as accepted with occupancy unchanged.
REQ-026 SHALL treat a pop on empty as impossible (out_valid=0 ignores out_ready).
REQ-027 SHALL, if the HALT record is dropped, still enter DRAIN, and overflow SHALL be 1.
REQ-028 SHALL wrap read and write pointers modulo DEPTH, with full/empty from an occupancy count of log2(DEPTH)+1 bits.
REQ-029 SHALL assert done=1 only in DONE.

Reset
REQ-030 SHALL, on rst=1 (asynchronous, any state including mid-drain), force:
- state IDLE.
- FIFO empty, pointers 0.
- out_valid=0; all out_* data 0.
- all counters 0; overflow=0; done=0.
REQ-031 SHALL begin capture on the first edge after rst deasserts only if en=1.

Configuration
REQ-032 SHALL, with macro TRACE_CYCLE_STAMP_EN defined, add output out_stamp, 16 bits, carrying cycle_count[15:0] sampled at capture, stored per entry.
REQ-033 SHALL, without TRACE_CYCLE_STAMP_EN, omit the out_stamp port and its storage; all other behaviour SHALL be identical.

Verification
REQ-034 Bench SHALL cover: reset, en=1, one retire pc=0x0000 reg_write=1 wr_reg=3 wr_data=0x0005, out_ready=1 -> next cycle out_valid=1 kind=0 out_reg=3 data0=0x0005; inst_count=1.
REQ-035 Bench SHALL cover: retire mem_write=1 mem_addr=0x0010 mem_data=0xBEEF -> kind=2 data0=0x0010 data1=0xBEEF.
REQ-036 Bench SHALL cover: out_ready=0, DEPTH=8, 10 retires -> 8 records held, drop_count=2, overflow=1, inst_count=10; then out_ready=1 drains 8 records in order.
REQ-037 Bench SHALL cover: hlt=1 at pc=0x0024 with 3 records queued -> kind=4 record last, no capture after it, done=1 one cycle after FIFO empties.
REQ-038 Bench SHALL cover: full FIFO with simultaneous pop and push -> occupancy stays 8, drop_count unchanged.
REQ-039 Bench SHALL cover: rst pulse mid-DRAIN -> out_valid=0, counters 0, done=0 immediately, before the next clock edge.
